// File: rtl/dds_hop_pkg.sv
// Shared types and constants for the DDS frequency-hop controller.
// LFSR uses taps 6 and 5 (x^7 + x^6 + 1), which gives a maximal-length 127-state sequence.
package dds_hop_pkg;
  localparam int LFSR_W      = 7;
  localparam int TAP_HI      = 6;
  localparam int TAP_LO      = 5;
  localparam int CH_W        = 3;
  localparam int DEF_PINC_W  = 16;
  localparam int DEF_DWELL_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SEND  = 2'd2,
    DWELL = 2'd3
  } hop_state_t;
endpackage

// File: rtl/dds_hop_lfsr.sv
// 7-bit Fibonacci LFSR for the hop sequence. Load reloads the seed and takes priority over advance.
// ch_nxt previews the channel that the next advance will produce. Seed 0 is mapped to 1.
module dds_hop_lfsr
  import dds_hop_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              adv,
  input  logic [LFSR_W-1:0] seed,
  output logic [CH_W-1:0]   ch_nxt
);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_adv;

  assign lfsr_adv = {lfsr_q[LFSR_W-2:0], lfsr_q[TAP_HI] ^ lfsr_q[TAP_LO]};
  assign ch_nxt   = lfsr_adv[CH_W-1:0];

  // A zero seed would lock the register at zero, so it is replaced with 1.
  always_ff @(posedge clk) begin
    if (rst)       lfsr_q <= LFSR_W'(1);
    else if (load) lfsr_q <= (seed == '0) ? LFSR_W'(1) : seed;
    else if (adv)  lfsr_q <= lfsr_adv;
  end

endmodule

// File: rtl/dds_hop_ctrl.sv
// Hop controller: offers one registered phase increment per hop to the DDS config stream.
// A hop period is dwell+2 cycles. tvalid holds in SEND until tready is seen, and only rst can drop it early.
module dds_hop_ctrl
  import dds_hop_pkg::*;
#(
  parameter int PINC_W  = DEF_PINC_W,
  parameter int DWELL_W = DEF_DWELL_W
) (
  input  logic               clk_100,
  input  logic               rst,
  input  logic               en,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [PINC_W-1:0]  base_pinc,
  input  logic [PINC_W-1:0]  step_pinc,
  input  logic [LFSR_W-1:0]  lfsr_seed,
  output logic               m_axis_config_tvalid,
  output logic [PINC_W-1:0]  m_axis_config_tdata,
  input  logic               m_axis_config_tready,
  output logic               hop_strobe,
  output logic [CH_W-1:0]    ch_idx,
  output logic               busy
);

  hop_state_t         state_q, state_nxt;
  logic               lfsr_load, lfsr_adv;
  logic [CH_W-1:0]    ch_nxt;
  logic [DWELL_W-1:0] dwell_m1_q, cnt_q;
  logic [PINC_W-1:0]  base_q, step_q, tdata_q;

  dds_hop_lfsr u_lfsr (
    .clk    (clk_100),
    .rst    (rst),
    .load   (lfsr_load),
    .adv    (lfsr_adv),
    .seed   (lfsr_seed),
    .ch_nxt (ch_nxt)
  );

  always_comb begin
    state_nxt = state_q;
    lfsr_load = 1'b0;
    lfsr_adv  = 1'b0;
    case (state_q)
      IDLE: begin
        lfsr_load = 1'b1;
        if (en) state_nxt = LOAD;
      end
      LOAD: begin
        lfsr_adv  = 1'b1;
        state_nxt = SEND;
      end
      SEND:  if (m_axis_config_tready) state_nxt = DWELL;
      DWELL: if (cnt_q == '0) state_nxt = en ? LOAD : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The dwell is stored as dwell_eff-1 so that zero and one both give a single DWELL cycle.
  always_ff @(posedge clk_100) begin
    if (rst) begin
      state_q    <= IDLE;
      ch_idx     <= '0;
      tdata_q    <= '0;
      cnt_q      <= '0;
      dwell_m1_q <= '0;
      base_q     <= '0;
      step_q     <= '0;
    end else begin
      state_q <= state_nxt;
      case (state_q)
        IDLE: if (en) begin
          dwell_m1_q <= (dwell == '0) ? '0 : dwell - DWELL_W'(1);
          base_q     <= base_pinc;
          step_q     <= step_pinc;
        end
        LOAD: begin
          ch_idx  <= ch_nxt;
          tdata_q <= base_q + PINC_W'(ch_nxt) * step_q;
        end
        SEND:  if (m_axis_config_tready) cnt_q <= dwell_m1_q;
        DWELL: if (cnt_q != '0) cnt_q <= cnt_q - DWELL_W'(1);
        default: ;
      endcase
    end
  end

  assign m_axis_config_tvalid = (state_q == SEND);
  assign m_axis_config_tdata  = tdata_q;
  assign hop_strobe           = m_axis_config_tvalid & m_axis_config_tready;
  assign busy                 = (state_q != IDLE);

endmodule

// File: tb/tb_dds_hop_ctrl.sv
// Directed bench for dds_hop_ctrl. Outputs are sampled 2 time units after each rising edge.
module tb_dds_hop_ctrl;
  logic        clk_100 = 1'b0;
  logic        rst = 1'b0, en = 1'b0, tready = 1'b0;
  logic [15:0] dwell = '0, base_pinc = '0, step_pinc = '0;
  logic [6:0]  lfsr_seed = '0;
  logic        tvalid, hop_strobe, busy;
  logic [15:0] tdata;
  logic [2:0]  ch_idx;

  int checks = 0;
  int fails  = 0;

  dds_hop_ctrl #(.PINC_W(16), .DWELL_W(16)) dut (
    .clk_100              (clk_100),
    .rst                  (rst),
    .en                   (en),
    .dwell                (dwell),
    .base_pinc            (base_pinc),
    .step_pinc            (step_pinc),
    .lfsr_seed            (lfsr_seed),
    .m_axis_config_tvalid (tvalid),
    .m_axis_config_tdata  (tdata),
    .m_axis_config_tready (tready),
    .hop_strobe           (hop_strobe),
    .ch_idx               (ch_idx),
    .busy                 (busy)
  );

  always #5 clk_100 = ~clk_100;

  task automatic step();
    @(posedge clk_100);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; tready = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic wait_strobe(output int n, output bit ok);
    n = 0; ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step();
      n++;
      if (hop_strobe === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; tready = 1'b1;
    step(); step();
    checks++; if (tvalid !== 1'b0) begin fails++; $display("FAIL reset_tvalid: got %b expected 0", tvalid); end
    checks++; if (hop_strobe !== 1'b0) begin fails++; $display("FAIL reset_strobe: got %b expected 0", hop_strobe); end
    checks++; if (tdata !== 16'h0000) begin fails++; $display("FAIL reset_tdata: got %h expected 0000", tdata); end
    checks++; if (ch_idx !== 3'd0) begin fails++; $display("FAIL reset_ch: got %0d expected 0", ch_idx); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (dut.u_lfsr.lfsr_q !== 7'h01) begin fails++; $display("FAIL reset_lfsr: got %h expected 01", dut.u_lfsr.lfsr_q); end
    rst = 1'b0; en = 1'b0;
  endtask

  task automatic test_basic_seq();
    logic [2:0]  exp_ch [3];
    logic [15:0] exp_td [3];
    int n; bit ok;
    exp_ch = '{3'd2, 3'd4, 3'd0};
    exp_td = '{16'h1800, 16'h2000, 16'h1000};
    do_reset();
    lfsr_seed = 7'h01; base_pinc = 16'h1000; step_pinc = 16'h0400; dwell = 16'd4;
    tready = 1'b1; en = 1'b1;
    for (int h = 0; h < 3; h++) begin
      wait_strobe(n, ok);
      checks++; if (!ok) begin fails++; $display("FAIL basic_timeout: hop %0d got none expected strobe", h); end
      checks++; if (ch_idx !== exp_ch[h]) begin fails++; $display("FAIL basic_ch: hop %0d got %0d expected %0d", h, ch_idx, exp_ch[h]); end
      checks++; if (tdata !== exp_td[h]) begin fails++; $display("FAIL basic_tdata: hop %0d got %h expected %h", h, tdata, exp_td[h]); end
      if (h > 0) begin
        checks++; if (n != 6) begin fails++; $display("FAIL basic_period: hop %0d got %0d expected 6", h, n); end
      end
    end
    en = 1'b0;
  endtask

  task automatic test_wrap();
    int n; bit ok;
    do_reset();
    lfsr_seed = 7'h01; base_pinc = 16'hFF00; step_pinc = 16'h0100; dwell = 16'd2;
    tready = 1'b1; en = 1'b1;
    wait_strobe(n, ok);
    checks++; if (!ok) begin fails++; $display("FAIL wrap_timeout: got none expected strobe"); end
    checks++; if (tdata !== 16'h0100) begin fails++; $display("FAIL wrap_tdata: got %h expected 0100", tdata); end
    checks++; if (ch_idx !== 3'd2) begin fails++; $display("FAIL wrap_ch: got %0d expected 2", ch_idx); end
    en = 1'b0;
  endtask

  task automatic test_seed0_dwell0();
    logic [2:0]  exp_ch [3];
    logic [15:0] exp_td [3];
    int n; bit ok;
    exp_ch = '{3'd2, 3'd4, 3'd0};
    exp_td = '{16'h1800, 16'h2000, 16'h1000};
    do_reset();
    lfsr_seed = 7'h00; base_pinc = 16'h1000; step_pinc = 16'h0400; dwell = 16'd0;
    tready = 1'b1; en = 1'b1;
    for (int h = 0; h < 3; h++) begin
      wait_strobe(n, ok);
      checks++; if (!ok) begin fails++; $display("FAIL seed0_timeout: hop %0d got none expected strobe", h); end
      checks++; if (ch_idx !== exp_ch[h]) begin fails++; $display("FAIL seed0_ch: hop %0d got %0d expected %0d", h, ch_idx, exp_ch[h]); end
      checks++; if (tdata !== exp_td[h]) begin fails++; $display("FAIL seed0_tdata: hop %0d got %h expected %h", h, tdata, exp_td[h]); end
      if (h > 0) begin
        checks++; if (n != 3) begin fails++; $display("FAIL dwell0_period: hop %0d got %0d expected 3", h, n); end
      end
    end
    en = 1'b0;
  endtask

  task automatic test_backpressure();
    int strobes;
    bit seen;
    do_reset();
    lfsr_seed = 7'h01; base_pinc = 16'h1000; step_pinc = 16'h0400; dwell = 16'd4;
    tready = 1'b0; en = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      if (tvalid === 1'b1) seen = 1'b1;
    end
    checks++; if (!seen) begin fails++; $display("FAIL bp_timeout: got no tvalid expected tvalid"); end
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++; if (tvalid !== 1'b1) begin fails++; $display("FAIL bp_tvalid: cycle %0d got %b expected 1", i, tvalid); end
      checks++; if (tdata !== 16'h1800) begin fails++; $display("FAIL bp_tdata: cycle %0d got %h expected 1800", i, tdata); end
      checks++; if (hop_strobe !== 1'b0) begin fails++; $display("FAIL bp_strobe_early: cycle %0d got %b expected 0", i, hop_strobe); end
    end
    tready = 1'b1;
    #1;
    checks++; if (hop_strobe !== 1'b1) begin fails++; $display("FAIL bp_strobe: got %b expected 1", hop_strobe); end
    step();
    tready = 1'b0;
    checks++; if (tvalid !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL bp_dwell_entry: got tvalid %b busy %b expected 0 1", tvalid, busy); end
    strobes = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (hop_strobe === 1'b1) strobes++;
      checks++; if (busy !== 1'b1) begin fails++; $display("FAIL bp_dwell_busy: cycle %0d got %b expected 1", i, busy); end
    end
    step();
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL bp_idle_busy: got %b expected 0", busy); end
    checks++; if (strobes != 0) begin fails++; $display("FAIL bp_extra_strobe: got %0d expected 0", strobes); end
  endtask

  task automatic test_reset_mid();
    int n; bit ok;
    do_reset();
    lfsr_seed = 7'h01; base_pinc = 16'h1000; step_pinc = 16'h0400; dwell = 16'd4;
    tready = 1'b1; en = 1'b1;
    for (int phase = 0; phase < 2; phase++) begin
      wait_strobe(n, ok);
      checks++; if (!ok || ch_idx !== 3'd2 || tdata !== 16'h1800) begin fails++; $display("FAIL mid_restart: phase %0d got ok %b ch %0d tdata %h expected 1 2 1800", phase, ok, ch_idx, tdata); end
      if (phase == 1) step();
      rst = 1'b1;
      step();
      checks++; if (tvalid !== 1'b0 || hop_strobe !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL mid_rst_ctl: phase %0d got tvalid %b strobe %b busy %b expected 0 0 0", phase, tvalid, hop_strobe, busy); end
      checks++; if (tdata !== 16'h0000 || ch_idx !== 3'd0) begin fails++; $display("FAIL mid_rst_data: phase %0d got tdata %h ch %0d expected 0000 0", phase, tdata, ch_idx); end
      rst = 1'b0;
    end
    wait_strobe(n, ok);
    checks++; if (!ok || ch_idx !== 3'd2 || tdata !== 16'h1800) begin fails++; $display("FAIL mid_final: got ok %b ch %0d tdata %h expected 1 2 1800", ok, ch_idx, tdata); end
    en = 1'b0;
  endtask

  task automatic test_lfsr_period();
    logic [6:0] m;
    int n; bit ok;
    do_reset();
    lfsr_seed = 7'h01; base_pinc = 16'h0000; step_pinc = 16'h0001; dwell = 16'd0;
    tready = 1'b1; en = 1'b1;
    m = 7'h01;
    for (int h = 1; h <= 127; h++) begin
      wait_strobe(n, ok);
      m = {m[5:0], m[6] ^ m[5]};
      checks++; if (!ok) begin fails++; $display("FAIL period_timeout: hop %0d got none expected strobe", h); end
      checks++; if (dut.u_lfsr.lfsr_q !== m) begin fails++; $display("FAIL period_state: hop %0d got %h expected %h", h, dut.u_lfsr.lfsr_q, m); end
      checks++; if (dut.u_lfsr.lfsr_q === 7'h00) begin fails++; $display("FAIL period_zero: hop %0d got 00 expected nonzero", h); end
      checks++; if (ch_idx !== m[2:0]) begin fails++; $display("FAIL period_ch: hop %0d got %0d expected %0d", h, ch_idx, m[2:0]); end
      checks++; if ((dut.u_lfsr.lfsr_q === 7'h01) != (h == 127)) begin fails++; $display("FAIL period_len: hop %0d got state %h expected return to 01 only at hop 127", h, dut.u_lfsr.lfsr_q); end
    end
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_seq();
    test_wrap();
    test_seed0_dwell0();
    test_backpressure();
    test_reset_mid();
    test_lfsr_period();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
